// File: rtl/sb_dmem.sv
// sb_dmem: little-endian byte/halfword/word data memory responder for the core's
// load/store bus. Accesses that cross a word boundary are split into two
// back-to-back word accesses, and busy_o is held high during the second one.
// Build option: define SB_MISALIGN_TRAP_EN to reject crossing accesses instead.
// When rejected, misalign_o pulses and the array is not touched.
// un_sign_i encoding: `UNSIGNED (1) zero-extends, `SIGNED (0) sign-extends.

`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif
`ifndef SIGNED
`define SIGNED 1'b0
`endif

module sb_dmem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic [31:0] mem_raddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  byte_sel_i,
  input  logic        un_sign_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        busy_o,
  output logic        misalign_o
);

  typedef enum logic [0:0] {IDLE, SPLIT} state_t;

  logic [31:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [1:0]      sel_q, sel_d;
  logic            uns_q, uns_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            load_q, load_d;
  logic [31:0]     hold_q, hold_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;
  logic            misalign_q, misalign_d;

  logic            req_store, req_load, req_mis;
  logic [AW+1:0]   req_addr;
  logic [1:0]      req_off;
  logic [AW-1:0]   req_idx;
  logic [2:0]      req_end, split_end;
  logic [3:0]      wr_en;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [31:0]     wr_data, rd_word;
  logic            unused_addr_bits;

  // Bytes moved by each size code.
  function automatic logic [2:0] size_bytes(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Rotate left by off bytes: data byte i lands in lane (off+i) mod 4.
  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[23:0], d[31:24]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[7:0], d[31:8]};
    endcase
  endfunction

  // Inverse of rotl_bytes: lane (off+i) mod 4 becomes data byte i.
  function automatic logic [31:0] rotr_bytes(input logic [31:0] d, input logic [1:0] off);
    case (off)
      2'd0:    return d;
      2'd1:    return {d[7:0], d[31:8]};
      2'd2:    return {d[15:0], d[31:16]};
      default: return {d[23:0], d[31:24]};
    endcase
  endfunction

  // Lanes at or above off come from the lower word, lanes below it from the next word.
  function automatic logic [31:0] assemble(input logic [31:0] lo, input logic [31:0] hi,
                                           input logic [1:0] off);
    logic [31:0] m;
    for (int l = 0; l < 4; l++)
      m[8*l +: 8] = (3'(l) >= {1'b0, off}) ? lo[8*l +: 8] : hi[8*l +: 8];
    return m;
  endfunction

  // Lanes off..min(end,4)-1 of the first word.
  function automatic logic [3:0] lanes_first(input logic [1:0] off, input logic [2:0] last);
    logic [3:0] en;
    for (int l = 0; l < 4; l++)
      en[l] = (3'(l) >= {1'b0, off}) && (3'(l) < last);
    return en;
  endfunction

  // Lanes 0..end-5 of the following word.
  function automatic logic [3:0] lanes_second(input logic [2:0] last);
    logic [3:0] en;
    for (int l = 0; l < 4; l++)
      en[l] = (4'(l) + 4'd4) < {1'b0, last};
    return en;
  endfunction

  // Sub-word loads are zero- or sign-extended; word loads pass through.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sel,
                                         input logic uns);
    case (sel)
      2'b00:   return (uns == `UNSIGNED) ? {24'd0, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'b01:   return (uns == `UNSIGNED) ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // A store takes priority over a simultaneous load.
  assign req_store = mem_we_i;
  assign req_load  = !mem_we_i && mem_re_i;
  assign req_addr  = mem_we_i ? mem_waddr_i[AW+1:0] : mem_raddr_i[AW+1:0];
  assign req_off   = req_addr[1:0];
  assign req_idx   = req_addr[AW+1:2];
  assign req_end   = {1'b0, req_off} + size_bytes(byte_sel_i);
  assign req_mis   = req_end > 3'd4;
  assign split_end = {1'b0, addr_q[1:0]} + size_bytes(sel_q);

  // Upper address bits are ignored; addresses wrap modulo DEPTH words.
  assign unused_addr_bits = ^{mem_raddr_i[31:AW+2], mem_waddr_i[31:AW+2]};

  assign rd_word = mem[rd_idx];

  // Next-state, array access and load-result logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    load_d     = load_q;
    hold_d     = hold_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    wr_en      = 4'b0000;
    wr_idx     = req_idx;
    rd_idx     = req_idx;
    wr_data    = rotl_bytes(mem_wdata_i, req_off);
    case (state_q)
      IDLE: begin
        if (req_store || req_load) begin
          if (!req_mis) begin
            if (req_store) begin
              wr_en = lanes_first(req_off, req_end);
            end else begin
              rdata_d  = extend(rotr_bytes(rd_word, req_off), byte_sel_i, un_sign_i);
              rvalid_d = 1'b1;
            end
          end else begin
`ifdef SB_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`else
            addr_d  = req_addr;
            sel_d   = byte_sel_i;
            uns_d   = un_sign_i;
            wdata_d = mem_wdata_i;
            load_d  = req_load;
            state_d = SPLIT;
            if (req_store) wr_en = lanes_first(req_off, req_end);
            else           hold_d = rd_word;
`endif
          end
        end
      end
      SPLIT: begin
        rd_idx  = addr_q[AW+1:2] + AW'(1);
        wr_idx  = addr_q[AW+1:2] + AW'(1);
        wr_data = rotl_bytes(wdata_q, addr_q[1:0]);
        if (load_q) begin
          rdata_d  = extend(rotr_bytes(assemble(hold_q, rd_word, addr_q[1:0]), addr_q[1:0]),
                            sel_q, uns_q);
          rvalid_d = 1'b1;
        end else begin
          wr_en = lanes_second(split_end);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers; reset aborts any split in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      sel_q      <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      load_q     <= 1'b0;
      hold_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      uns_q      <= uns_d;
      wdata_q    <= wdata_d;
      load_q     <= load_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
    end
  end

  // Byte-lane writes into the word array (contents survive reset).
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (wr_en[l]) mem[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign busy_o     = (state_q == SPLIT);
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_sb_dmem.sv
// tb_sb_dmem: directed scoreboard bench for sb_dmem.

`ifndef UNSIGNED
`define UNSIGNED 1'b1
`endif
`ifndef SIGNED
`define SIGNED 1'b0
`endif

module tb_sb_dmem;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] LAST = 32'(4 * DEPTH - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_raddr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [1:0]  byte_sel = 2'b10;
  logic        un_sign = 1'b0;
  logic [31:0] rdata_o;
  logic        rvalid_o, busy_o, misalign_o;

  int vectors = 0;
  int errs = 0;
  logic [31:0] exp_q [$];

  sb_dmem #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re), .mem_raddr_i(mem_raddr),
    .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .byte_sel_i(byte_sel), .un_sign_i(un_sign),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .busy_o(busy_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_store(input logic [31:0] addr, input logic [1:0] sel,
                          input logic [31:0] data, input logic split, input string tag);
    mem_we = 1'b1; mem_waddr = addr; mem_wdata = data; byte_sel = sel;
    @(negedge clk);
    mem_we = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, split});
    if (split) begin
      @(negedge clk);
      chk({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
    end
    $display("store %s addr=0x%08h sel=%0d data=0x%08h", tag, addr, sel, data);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] sel, input logic uns,
                         input logic [31:0] expv, input int lat, input string tag);
    int cyc;
    bit seen;
    logic [31:0] e;
    mem_re = 1'b1; mem_raddr = addr; byte_sel = sel; un_sign = uns;
    exp_q.push_back(expv);
    @(negedge clk);
    mem_re = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy_o}, (lat == 2) ? 32'd1 : 32'd0);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 8) begin
      if (rvalid_o === 1'b1) seen = 1'b1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_lat"}, seen ? 32'(cyc) : 32'd0, 32'(lat));
    e = exp_q.pop_front();
    chk(tag, rdata_o, e);
    $display("load  %s addr=0x%08h sel=%0d uns=%0d rdata=0x%08h exp=0x%08h lat=%0d",
             tag, addr, sel, uns, rdata_o, e, cyc);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, rvalid_o}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Aligned word, then byte store with signed/unsigned reloads
    do_store(32'h10, 2'b10, 32'hDEADBEEF, 1'b0, "sw10");
    do_load(32'h10, 2'b10, `SIGNED, 32'hDEADBEEF, 1, "lw10");
    do_store(32'h13, 2'b00, 32'h00000080, 1'b0, "sb13");
    do_load(32'h13, 2'b00, `SIGNED, 32'hFFFFFF80, 1, "lb13");
    do_load(32'h13, 2'b00, `UNSIGNED, 32'h00000080, 1, "lbu13");
    do_load(32'h10, 2'b10, `SIGNED, 32'h80ADBEEF, 1, "lw10b");

    // Store and load both asserted: the store wins, no load result
    mem_we = 1'b1; mem_re = 1'b1; mem_waddr = 32'h20; mem_raddr = 32'h20;
    mem_wdata = 32'h5; byte_sel = 2'b10;
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b0;
    chk("both_rvalid0", {31'd0, rvalid_o}, 32'd0);
    @(negedge clk);
    chk("both_rvalid1", {31'd0, rvalid_o}, 32'd0);
    do_load(32'h20, 2'b10, `SIGNED, 32'h00000005, 1, "lw20");

`ifndef SB_MISALIGN_TRAP_EN
    // Word split across 0x0C/0x10
    do_store(32'h0C, 2'b10, 32'h00000000, 1'b0, "sw0c");
    do_store(32'h0E, 2'b10, 32'h11223344, 1'b1, "sw0e");
    do_load(32'h0C, 2'b10, `SIGNED, 32'h33440000, 1, "lw0c");
    do_load(32'h10, 2'b10, `SIGNED, 32'h80AD1122, 1, "lw10c");
    do_load(32'h0E, 2'b10, `SIGNED, 32'h11223344, 2, "lw0e");

    // Halfword wrapping from the last word to word 0
    do_store(32'h0, 2'b10, 32'h00000000, 1'b0, "sw0");
    do_store(LAST - 32'd3, 2'b10, 32'h00000000, 1'b0, "swlast");
    do_store(LAST, 2'b01, 32'h0000BEEF, 1'b1, "shwrap");
    do_load(LAST, 2'b00, `UNSIGNED, 32'h000000EF, 1, "lbulast");
    do_load(32'h0, 2'b00, `UNSIGNED, 32'h000000BE, 1, "lbu0");
    do_load(LAST, 2'b01, `SIGNED, 32'hFFFFBEEF, 2, "lhwrap");

    // Reset during the second half of a split load
    mem_re = 1'b1; mem_raddr = 32'h0E; byte_sel = 2'b10; un_sign = `SIGNED;
    @(negedge clk);
    mem_re = 1'b0;
    chk("abort_ld_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_ld_rdata", rdata_o, 32'd0);
    chk("abort_ld_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("abort_ld_busy0", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_ld_rvalid_a", {31'd0, rvalid_o}, 32'd0);
    @(negedge clk);
    chk("abort_ld_rvalid_b", {31'd0, rvalid_o}, 32'd0);
    $display("abort split load at 0x0000000e");
    do_load(32'h10, 2'b10, `SIGNED, 32'h80AD1122, 1, "lw10_post");

    // Reset during a split store: first half stays, second half never happens
    do_store(32'h24, 2'b10, 32'h00000000, 1'b0, "sw24");
    do_store(32'h28, 2'b10, 32'h12345678, 1'b0, "sw28");
    mem_we = 1'b1; mem_waddr = 32'h26; mem_wdata = 32'hAABBCCDD; byte_sel = 2'b10;
    @(negedge clk);
    mem_we = 1'b0;
    chk("abort_st_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_st_busy0", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("abort split store at 0x00000026");
    do_load(32'h24, 2'b10, `SIGNED, 32'hCCDD0000, 1, "lw24");
    do_load(32'h28, 2'b10, `SIGNED, 32'h12345678, 1, "lw28");
`else
    // Misaligned requests trap and leave the array alone
    do_store(32'h0, 2'b10, 32'h01020304, 1'b0, "sw0");
    do_store(32'h4, 2'b10, 32'h05060708, 1'b0, "sw4");
    mem_re = 1'b1; mem_raddr = 32'h03; byte_sel = 2'b01; un_sign = `SIGNED;
    @(negedge clk);
    mem_re = 1'b0;
    chk("trap_ld_mis", {31'd0, misalign_o}, 32'd1);
    chk("trap_ld_rvalid", {31'd0, rvalid_o}, 32'd0);
    chk("trap_ld_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    chk("trap_ld_mis_end", {31'd0, misalign_o}, 32'd0);
    chk("trap_ld_rvalid_end", {31'd0, rvalid_o}, 32'd0);
    $display("trap halfword load at 0x00000003");
    mem_we = 1'b1; mem_waddr = 32'h02; mem_wdata = 32'hFFFFFFFF; byte_sel = 2'b10;
    @(negedge clk);
    mem_we = 1'b0;
    chk("trap_st_mis", {31'd0, misalign_o}, 32'd1);
    chk("trap_st_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    $display("trap word store at 0x00000002");
    do_load(32'h0, 2'b10, `SIGNED, 32'h01020304, 1, "lw0");
    do_load(32'h4, 2'b10, `SIGNED, 32'h05060708, 1, "lw4");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
